// File: rtl/pio_fifo_pair.sv
// pio_fifo_pair: TX/RX FIFO pair between the host bus and one PIO machine.
// Optional PIO_FIFO_JOIN_EN lets one direction borrow the other's storage.
module pio_fifo_pair #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(2*DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
`ifdef PIO_FIFO_JOIN_EN
  input  logic             join_tx,
  input  logic             join_rx,
`endif
  input  logic [WIDTH-1:0] tx_wdata,
  input  logic             tx_wr,
  output logic             tx_full,
  output logic [LW-1:0]    tx_level,
  input  logic             sm_pull,
  output logic [WIDTH-1:0] sm_din,
  output logic             sm_empty,
  input  logic             sm_push,
  input  logic [WIDTH-1:0] sm_dout,
  output logic             sm_full,
  input  logic             rx_rd,
  output logic [WIDTH-1:0] rx_rdata,
  output logic             rx_empty,
  output logic [LW-1:0]    rx_level,
  input  logic [1:0]       flag_clr,
  output logic             tx_overflow,
  output logic             rx_underflow
);

  localparam int PW = LW - 1;
  localparam logic [LW-1:0] CAP1 = LW'(DEPTH);
  localparam logic [LW-1:0] CAP2 = LW'(2*DEPTH);

  logic [WIDTH-1:0] mem [2*DEPTH];
  logic [PW-1:0]    tx_wp, tx_rp, rx_wp, rx_rp;
  logic [PW-1:0]    tx_msk, rx_msk, rx_base;
  logic [LW-1:0]    tx_cap, rx_cap;
  logic             jt, jr, flush;
  logic             tx_we, tx_re, rx_we, rx_re;

`ifdef PIO_FIFO_JOIN_EN
  logic jtx_q, jrx_q;

  // Both joins set cancel out; any edge on either input flushes.
  assign jt    = join_tx & ~join_rx;
  assign jr    = join_rx & ~join_tx;
  assign flush = clear | (join_tx != jtx_q)
                       | (join_rx != jrx_q);

  always_ff @(posedge clk) begin
    jtx_q <= join_tx;
    jrx_q <= join_rx;
  end
`else
  assign jt    = 1'b0;
  assign jr    = 1'b0;
  assign flush = clear;
`endif

  always_comb begin
    tx_cap = jt ? CAP2 : (jr ? '0 : CAP1);
    rx_cap = jr ? CAP2 : (jt ? '0 : CAP1);
  end

  assign tx_msk  = PW'(tx_cap - 1'b1);
  assign rx_msk  = PW'(rx_cap - 1'b1);
  assign rx_base = jr ? '0 : PW'(DEPTH);

  assign tx_full  = (tx_level == tx_cap);
  assign sm_empty = (tx_level == '0);
  assign sm_full  = (rx_level == rx_cap);
  assign rx_empty = (rx_level == '0);

  assign tx_we = tx_wr   & ~tx_full  & ~flush;
  assign tx_re = sm_pull & ~sm_empty & ~flush;
  assign rx_we = sm_push & ~sm_full  & ~flush;
  assign rx_re = rx_rd   & ~rx_empty & ~flush;

  assign sm_din   = sm_empty ? '0 : mem[tx_rp];
  assign rx_rdata = rx_empty ? '0 : mem[rx_base | rx_rp];

  always_ff @(posedge clk) begin
    if (tx_we) mem[tx_wp] <= tx_wdata;
    if (rx_we) mem[rx_base | rx_wp] <= sm_dout;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_level <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_level <= '0;
    end else begin
      if (tx_we) tx_wp <= (tx_wp + 1'b1) & tx_msk;
      if (tx_re) tx_rp <= (tx_rp + 1'b1) & tx_msk;
      if (rx_we) rx_wp <= (rx_wp + 1'b1) & rx_msk;
      if (rx_re) rx_rp <= (rx_rp + 1'b1) & rx_msk;
      tx_level <= tx_level + LW'(tx_we) - LW'(tx_re);
      rx_level <= rx_level + LW'(rx_we) - LW'(rx_re);
    end
  end

  // Flags survive clear; a new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      tx_overflow  <= (tx_wr & tx_full)
                    | (tx_overflow & ~flag_clr[0]);
      rx_underflow <= (rx_rd & rx_empty)
                    | (rx_underflow & ~flag_clr[1]);
    end
  end

endmodule

// File: tb/tb_pio_fifo_pair.sv
// tb_pio_fifo_pair: directed self-checking bench for pio_fifo_pair.
// Define PIO_FIFO_JOIN_EN to also exercise the joined-FIFO mode.
module tb_pio_fifo_pair;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [31:0] tx_wdata, sm_dout;
  logic        tx_wr, sm_pull, sm_push, rx_rd;
  logic [1:0]  flag_clr;
  logic        tx_full, sm_empty, sm_full, rx_empty;
  logic [3:0]  tx_level, rx_level;
  logic [31:0] sm_din, rx_rdata;
  logic        tx_overflow, rx_underflow;
`ifdef PIO_FIFO_JOIN_EN
  logic        join_tx, join_rx;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_fifo_pair #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
`ifdef PIO_FIFO_JOIN_EN
    .join_tx(join_tx), .join_rx(join_rx),
`endif
    .tx_wdata(tx_wdata), .tx_wr(tx_wr),
    .tx_full(tx_full), .tx_level(tx_level),
    .sm_pull(sm_pull), .sm_din(sm_din),
    .sm_empty(sm_empty), .sm_push(sm_push),
    .sm_dout(sm_dout), .sm_full(sm_full),
    .rx_rd(rx_rd), .rx_rdata(rx_rdata),
    .rx_empty(rx_empty), .rx_level(rx_level),
    .flag_clr(flag_clr),
    .tx_overflow(tx_overflow),
    .rx_underflow(rx_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_wr = 0; sm_pull = 0; sm_push = 0;
    rx_rd = 0; clear = 0; flag_clr = 2'b00;
  endtask

  task automatic test_reset();
    idle();
    tx_wdata = '0; sm_dout = '0;
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    checks++;
    if ({tx_full, sm_empty, sm_full, rx_empty} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_status: got %b want 0101",
               {tx_full, sm_empty, sm_full, rx_empty});
    end
    checks++;
    if ({tx_level, rx_level} !== 8'h00) begin
      errors++;
      $display("FAIL reset_levels: got %h want 00",
               {tx_level, rx_level});
    end
    checks++;
    if ({tx_overflow, rx_underflow} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00",
               {tx_overflow, rx_underflow});
    end
    checks++;
    if (sm_din !== 32'h0 || rx_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h want 0/0",
               sm_din, rx_rdata);
    end
  endtask

  task automatic test_tx_fill();
    for (int i = 0; i < 4; i++) begin
      tx_wdata = 32'(8'h11 * (i + 1));
      tx_wr = 1;
      tick();
    end
    idle();
    checks++;
    if (tx_level !== 4'd4 || tx_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_level: got %0d/%b want 4/1",
               tx_level, tx_full);
    end
    tx_wdata = 32'h55; tx_wr = 1;
    tick();
    idle();
    checks++;
    if (tx_overflow !== 1'b1 || tx_level !== 4'd4) begin
      errors++;
      $display("FAIL overflow: got %b/%0d want 1/4",
               tx_overflow, tx_level);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sm_din !== 32'(8'h11 * (i + 1))) begin
        errors++;
        $display("FAIL pull_%0d: got %h want %h", i,
                 sm_din, 32'(8'h11 * (i + 1)));
      end
      sm_pull = 1;
      tick();
    end
    idle();
    checks++;
    if (sm_empty !== 1'b1 || sm_din !== 32'h0) begin
      errors++;
      $display("FAIL drained: got %b/%h want 1/0",
               sm_empty, sm_din);
    end
    flag_clr = 2'b01;
    tick();
    idle();
    checks++;
    if (tx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b want 0", tx_overflow);
    end
  endtask

  task automatic test_empty_wr_rd();
    tx_wdata = 32'hA5; tx_wr = 1; sm_pull = 1;
    tick();
    idle();
    checks++;
    if (tx_level !== 4'd1 || sm_din !== 32'hA5) begin
      errors++;
      $display("FAIL empty_wr_rd: got %0d/%h want 1/a5",
               tx_level, sm_din);
    end
    sm_pull = 1;
    tick();
    idle();
  endtask

  task automatic test_rx_simul();
    for (int i = 0; i < 2; i++) begin
      sm_dout = 32'h1001 + 32'(i); sm_push = 1;
      tick();
    end
    idle();
    checks++;
    if (rx_level !== 4'd2 || rx_rdata !== 32'h1001) begin
      errors++;
      $display("FAIL rx_pre: got %0d/%h want 2/1001",
               rx_level, rx_rdata);
    end
    sm_dout = 32'hBEEF; sm_push = 1; rx_rd = 1;
    tick();
    idle();
    checks++;
    if (rx_level !== 4'd2 || rx_rdata !== 32'h1002) begin
      errors++;
      $display("FAIL rx_simul: got %0d/%h want 2/1002",
               rx_level, rx_rdata);
    end
    rx_rd = 1;
    tick();
    idle();
    checks++;
    if (rx_rdata !== 32'hBEEF) begin
      errors++;
      $display("FAIL rx_tail: got %h want beef", rx_rdata);
    end
    rx_rd = 1;
    tick();
    idle();
    checks++;
    if (rx_empty !== 1'b1 || rx_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rx_drain: got %b/%h want 1/0",
               rx_empty, rx_rdata);
    end
  endtask

  task automatic test_underflow_stall();
    rx_rd = 1;
    tick();
    idle();
    checks++;
    if (rx_underflow !== 1'b1 || rx_level !== 4'd0) begin
      errors++;
      $display("FAIL underflow: got %b/%0d want 1/0",
               rx_underflow, rx_level);
    end
    flag_clr = 2'b10;
    tick();
    idle();
    checks++;
    if (rx_underflow !== 1'b0) begin
      errors++;
      $display("FAIL unf_clr: got %b want 0", rx_underflow);
    end
    rx_rd = 1; flag_clr = 2'b10;
    tick();
    idle();
    checks++;
    if (rx_underflow !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got %b want 1", rx_underflow);
    end
    flag_clr = 2'b10;
    tick();
    idle();
    for (int k = 0; k < 6; k++) begin
      sm_dout = 32'h200 + 32'(k); sm_push = 1;
      tick();
    end
    idle();
    checks++;
    if (rx_level !== 4'd4 || sm_full !== 1'b1) begin
      errors++;
      $display("FAIL stall: got %0d/%b want 4/1",
               rx_level, sm_full);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx_rdata !== 32'h200 + 32'(k)) begin
        errors++;
        $display("FAIL stall_rd_%0d: got %h want %h", k,
                 rx_rdata, 32'h200 + 32'(k));
      end
      rx_rd = 1;
      tick();
    end
    idle();
  endtask

  task automatic test_clear();
    rx_rd = 1;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tx_wdata = 32'h30 + 32'(i); tx_wr = 1;
      sm_dout = 32'h40 + 32'(i); sm_push = (i < 2);
      tick();
    end
    idle();
    checks++;
    if (tx_level !== 4'd3 || rx_level !== 4'd2) begin
      errors++;
      $display("FAIL clr_pre: got %0d/%0d want 3/2",
               tx_level, rx_level);
    end
    clear = 1; tx_wr = 1; sm_push = 1;
    tick();
    idle();
    checks++;
    if ({tx_level, rx_level} !== 8'h00
        || sm_empty !== 1'b1 || rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL clear: got %h/%b%b want 00/11",
               {tx_level, rx_level}, sm_empty, rx_empty);
    end
    checks++;
    if ({tx_overflow, rx_underflow} !== 2'b01) begin
      errors++;
      $display("FAIL clr_flags: got %b want 01",
               {tx_overflow, rx_underflow});
    end
    flag_clr = 2'b11;
    tick();
    idle();
  endtask

`ifdef PIO_FIFO_JOIN_EN
  task automatic test_join();
    join_tx = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tx_wdata = 32'h100 + 32'(i); tx_wr = 1;
      tick();
    end
    idle();
    checks++;
    if (tx_level !== 4'd8 || tx_full !== 1'b1
        || tx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL join_fill: got %0d/%b/%b want 8/1/0",
               tx_level, tx_full, tx_overflow);
    end
    checks++;
    if ({sm_full, rx_empty} !== 2'b11 || rx_level !== 4'd0) begin
      errors++;
      $display("FAIL join_rx: got %b/%0d want 11/0",
               {sm_full, rx_empty}, rx_level);
    end
    tx_wdata = 32'h1FF; tx_wr = 1;
    tick();
    idle();
    checks++;
    if (tx_overflow !== 1'b1 || sm_din !== 32'h100) begin
      errors++;
      $display("FAIL join_ovf: got %b/%h want 1/100",
               tx_overflow, sm_din);
    end
    for (int i = 0; i < 7; i++) begin
      sm_pull = 1;
      tick();
    end
    idle();
    checks++;
    if (sm_din !== 32'h107 || tx_level !== 4'd1) begin
      errors++;
      $display("FAIL join_tail: got %h/%0d want 107/1",
               sm_din, tx_level);
    end
    join_tx = 0;
    tick();
    checks++;
    if (tx_level !== 4'd0 || sm_empty !== 1'b1) begin
      errors++;
      $display("FAIL join_flush: got %0d/%b want 0/1",
               tx_level, sm_empty);
    end
    flag_clr = 2'b11;
    tick();
    idle();
  endtask
`endif

  initial begin
`ifdef PIO_FIFO_JOIN_EN
    join_tx = 0; join_rx = 0;
`endif
    test_reset();
    test_tx_fill();
    test_empty_wr_rd();
    test_rx_simul();
    test_underflow_stall();
    test_clear();
`ifdef PIO_FIFO_JOIN_EN
    test_join();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
